// File: rtl/uart_pkg.sv
// Shared definitions for the UART command scheduler: opcodes, response codes,
// FSM encoding and the counter width used by both timeouts.
package uart_pkg;

    localparam int unsigned BAUD_CLK_HZ = 115200;
    localparam int unsigned CNT_W       = 18;

    // Request opcodes
    localparam logic [7:0] CMD_STATUS = 8'h00;
    localparam logic [7:0] CMD_TEMP   = 8'h01;
    localparam logic [7:0] CMD_HUM    = 8'h02;
    localparam logic [7:0] CMD_DIAG   = 8'h03;

    // Response codes
    localparam logic [7:0] RSP_STATUS   = 8'h07;
    localparam logic [7:0] RSP_OK       = 8'h08;
    localparam logic [7:0] RSP_BAD_CMD  = 8'hE1;
    localparam logic [7:0] RSP_BAD_ADDR = 8'hE2;
    localparam logic [7:0] RSP_SNS_ERR  = 8'hE3;
    localparam logic [7:0] RSP_SNS_TMO  = 8'hE4;

    typedef enum logic [2:0] {
        StIdle,
        StWaitAddr,
        StCheck,
        StWaitSns,
        StResp,
        StSend1,
        StSend2
    } sched_state_e;

    // Opcodes are contiguous from STATUS up to DIAG.
    function automatic logic is_valid_cmd(input logic [7:0] cmd);
        return cmd <= CMD_DIAG;
    endfunction

endpackage

// File: rtl/rx_edge_detect.sv
// Turns the receiver's byte-ready level into one single-cycle event per byte.
module rx_edge_detect (
    input  logic clk_115200hz,
    input  logic rst_n,
    input  logic rx_valid,
    output logic byte_evt
);

    logic rx_valid_q;

    // Remember last cycle's level so a long level yields only one event.
    always_ff @(posedge clk_115200hz or negedge rst_n) begin
        if (!rst_n) begin
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= rx_valid;
        end
    end

    assign byte_evt = rx_valid & ~rx_valid_q;

endmodule

// File: rtl/uart_cmd_scheduler.sv
// Command sequencer: assembles cmd/addr from the UART receiver, dispatches to a
// sensor channel with timeout, and returns a two-byte response via the transmitter.
module uart_cmd_scheduler
    import uart_pkg::*;
#(
    parameter int unsigned N_SNS       = 32,
    parameter int unsigned ADDR_W      = 5,
    parameter int unsigned GAP_TIMEOUT = BAUD_CLK_HZ / 10,
    parameter int unsigned SNS_TIMEOUT = 2 * BAUD_CLK_HZ
) (
    input  logic              clk_115200hz,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [ADDR_W-1:0] sns_sel,
    output logic [7:0]        sns_cmd,
    output logic              sns_req,
    input  logic              sns_done,
    input  logic              sns_err,
    input  logic [7:0]        sns_data,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic              busy,
    output logic              ovr
);

    localparam logic [CNT_W-1:0] GAP_LIM   = CNT_W'(GAP_TIMEOUT);
    localparam logic [CNT_W-1:0] SNS_LIM   = CNT_W'(SNS_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [8:0]       N_SNS_LIM = 9'(N_SNS);

    sched_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [7:0]        addr_q, addr_d;
    logic [ADDR_W-1:0] sns_sel_q, sns_sel_d;
    logic [7:0]        sns_cmd_q, sns_cmd_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        payload_q, payload_d;
    logic              ovr_q, ovr_d;
    logic              ovr_clr;
    logic              byte_evt;

    rx_edge_detect u_rx_edge_detect (
        .clk_115200hz (clk_115200hz),
        .rst_n        (rst_n),
        .rx_valid     (rx_valid),
        .byte_evt     (byte_evt)
    );

    // State and datapath registers; reset aborts any request in flight.
    always_ff @(posedge clk_115200hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            cmd_q     <= '0;
            addr_q    <= '0;
            sns_sel_q <= '0;
            sns_cmd_q <= '0;
            tx_data_q <= '0;
            payload_q <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            addr_q    <= addr_d;
            sns_sel_q <= sns_sel_d;
            sns_cmd_q <= sns_cmd_d;
            tx_data_q <= tx_data_d;
            payload_q <= payload_d;
            ovr_q     <= ovr_d;
        end
    end

    // Next-state, response selection and the transmitter start strobe.
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        sns_sel_d = sns_sel_q;
        sns_cmd_d = sns_cmd_q;
        tx_data_d = tx_data_q;
        payload_d = payload_q;
        ovr_clr   = 1'b0;
        tx_start  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (byte_evt) begin
                    cmd_d   = rx_data;
                    state_d = StWaitAddr;
                end
            end
            StWaitAddr: begin
                if (byte_evt) begin
                    addr_d  = rx_data;
                    state_d = StCheck;
                end else if (cnt_q >= GAP_LIM) begin
                    state_d = StIdle;
                end
            end
            StCheck: begin
                if (!is_valid_cmd(cmd_q)) begin
                    tx_data_d = RSP_BAD_CMD;
                    payload_d = cmd_q;
                    state_d   = StResp;
                end else if ({1'b0, addr_q} >= N_SNS_LIM) begin
                    tx_data_d = RSP_BAD_ADDR;
                    payload_d = addr_q;
                    state_d   = StResp;
                end else if (cmd_q == CMD_STATUS) begin
                    tx_data_d = RSP_STATUS;
                    payload_d = {ovr_q, 2'b00, addr_q[4:0]};
                    ovr_clr   = 1'b1;
                    state_d   = StResp;
                end else begin
                    sns_sel_d = addr_q[ADDR_W-1:0];
                    sns_cmd_d = cmd_q;
                    state_d   = StWaitSns;
                end
            end
            StWaitSns: begin
                // A completion in the timeout cycle still counts as a completion.
                if (sns_done) begin
                    tx_data_d = sns_err ? RSP_SNS_ERR : RSP_OK;
                    payload_d = sns_data;
                    state_d   = StResp;
                end else if (cnt_q >= SNS_LIM) begin
                    tx_data_d = RSP_SNS_TMO;
                    payload_d = 8'h00;
                    state_d   = StResp;
                end
            end
            StResp: begin
                // Code byte is on tx_data; swap in the payload as the start is taken.
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    tx_data_d = payload_q;
                    state_d   = StSend1;
                end
            end
            StSend1: begin
                // First cycle skipped: tx_busy only rises the cycle after tx_start.
                if (cnt_q != '0 && !tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = StSend2;
                end
            end
            StSend2: begin
                if (cnt_q != '0 && !tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Late bytes are dropped; setting wins over the STATUS clear.
        ovr_d = ovr_q;
        if (byte_evt && state_q != StIdle && state_q != StWaitAddr) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end

        // Shared timeout counter: cleared on every state entry, saturating.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign sns_sel = sns_sel_q;
    assign sns_cmd = sns_cmd_q;
    assign sns_req = (state_q == StWaitSns);
    assign tx_data = tx_data_q;
    assign busy    = (state_q != StIdle);
    assign ovr     = ovr_q;

endmodule

// File: tb/tb_uart_cmd_scheduler.sv
// Directed bench for uart_cmd_scheduler with a small transmitter model.
module tb_uart_cmd_scheduler;

    localparam int unsigned GAP_T = 200;
    localparam int unsigned SNS_T = 300;

    logic       clk_115200hz;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [4:0] sns_sel;
    logic [7:0] sns_cmd;
    logic       sns_req;
    logic       sns_done;
    logic       sns_err;
    logic [7:0] sns_data;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic       busy;
    logic       ovr;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         tx_cnt = 0;
    int         req_cycles = 0;
    int         busy_left = 0;
    logic [7:0] tx_log [4];

    uart_cmd_scheduler #(
        .N_SNS       (32),
        .ADDR_W      (5),
        .GAP_TIMEOUT (GAP_T),
        .SNS_TIMEOUT (SNS_T)
    ) dut (
        .clk_115200hz (clk_115200hz),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .sns_sel      (sns_sel),
        .sns_cmd      (sns_cmd),
        .sns_req      (sns_req),
        .sns_done     (sns_done),
        .sns_err      (sns_err),
        .sns_data     (sns_data),
        .tx_data      (tx_data),
        .tx_start     (tx_start),
        .tx_busy      (tx_busy),
        .busy         (busy),
        .ovr          (ovr)
    );

    initial begin
        clk_115200hz = 1'b0;
        forever #5 clk_115200hz = ~clk_115200hz;
    end

    // Transmitter model: busy rises the cycle after tx_start, stays high 8 cycles.
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge clk_115200hz);
            if (tx_start) begin
                tx_busy <= 1'b1;
                busy_left = 8;
            end else if (busy_left > 1) begin
                busy_left--;
            end else begin
                busy_left = 0;
                tx_busy <= 1'b0;
            end
        end
    end

    // Monitor: log transmitted bytes and count request cycles.
    initial begin
        forever begin
            @(negedge clk_115200hz);
            if (sns_req) req_cycles++;
            if (tx_start) begin
                if (tx_cnt < 4) tx_log[tx_cnt] = tx_data;
                tx_cnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    task automatic clear_log();
        #1;
        tx_cnt     = 0;
        req_cycles = 0;
        for (int i = 0; i < 4; i++) tx_log[i] = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk_115200hz);
        rx_data  = b;
        rx_valid = 1'b1;
        repeat (hold) @(negedge clk_115200hz);
        rx_valid = 1'b0;
        @(negedge clk_115200hz);
    endtask

    task automatic wait_idle(input int max_cyc, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_115200hz);
            #1;
            if (tx_cnt >= 2 && !busy) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk_115200hz);
        n_cmp++;
        if ({sns_req, tx_start, busy, ovr} !== 4'b0000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {sns_req, tx_start, busy, ovr});
        end
        n_cmp++;
        if ({sns_sel, sns_cmd, tx_data} !== 21'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0", {sns_sel, sns_cmd, tx_data});
        end
        rst_n = 1'b1;
        @(negedge clk_115200hz);
    endtask

    task automatic test_sensor_ok();
        int n;
        bit to;
        bit saw_high;
        bit busy_after;
        clear_log();
        send_byte(8'h01, 1);
        send_byte(8'h03, 1);
        for (int i = 0; i < 50 && !sns_req; i++) @(negedge clk_115200hz);
        n_cmp++;
        if (sns_req !== 1'b1) begin
            n_bad++;
            $display("FAIL ok_req_rise: got %b want 1", sns_req);
        end
        n_cmp++;
        if ({sns_sel, sns_cmd} !== {5'd3, 8'h01}) begin
            n_bad++;
            $display("FAIL ok_sel_cmd: got %h/%h want 03/01", sns_sel, sns_cmd);
        end
        n = 1;
        while (n < 100) begin
            @(negedge clk_115200hz);
            if (!sns_req) break;
            n++;
        end
        sns_done = 1'b1;
        sns_err  = 1'b0;
        sns_data = 8'h19;
        @(negedge clk_115200hz);
        sns_done = 1'b0;
        n_cmp++;
        if (n != 100 || sns_req !== 1'b0) begin
            n_bad++;
            $display("FAIL ok_req_len: got %0d cycles, req=%b want 100, 0", n, sns_req);
        end
        saw_high   = 1'b0;
        busy_after = 1'b0;
        to         = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_115200hz);
            #1;
            if (tx_cnt >= 2 && tx_busy) saw_high = 1'b1;
            if (tx_cnt >= 2 && saw_high && !tx_busy && busy) busy_after = 1'b1;
            if (tx_cnt >= 2 && !busy) begin
                to = 1'b0;
                break;
            end
        end
        n_cmp++;
        if (to || tx_cnt != 2 || tx_log[0] !== 8'h08 || tx_log[1] !== 8'h19) begin
            n_bad++;
            $display("FAIL ok_tx: got n=%0d %h %h to=%b want n=2 08 19", tx_cnt, tx_log[0],
                     tx_log[1], to);
        end
        n_cmp++;
        if ({saw_high, busy_after} !== 2'b11) begin
            n_bad++;
            $display("FAIL ok_busy_fall: got %b want 11", {saw_high, busy_after});
        end
    endtask

    task automatic test_bad_cmd();
        bit to;
        clear_log();
        send_byte(8'h05, 1);
        send_byte(8'h00, 1);
        wait_idle(200, to);
        n_cmp++;
        if (to || tx_cnt != 2 || tx_log[0] !== 8'hE1 || tx_log[1] !== 8'h05) begin
            n_bad++;
            $display("FAIL bad_cmd_tx: got n=%0d %h %h want n=2 e1 05", tx_cnt, tx_log[0],
                     tx_log[1]);
        end
        n_cmp++;
        if (req_cycles != 0) begin
            n_bad++;
            $display("FAIL bad_cmd_noreq: got %0d req cycles want 0", req_cycles);
        end
    endtask

    task automatic test_bad_addr();
        bit to;
        clear_log();
        send_byte(8'h02, 1);
        send_byte(8'h20, 1);
        wait_idle(200, to);
        n_cmp++;
        if (to || tx_cnt != 2 || tx_log[0] !== 8'hE2 || tx_log[1] !== 8'h20) begin
            n_bad++;
            $display("FAIL bad_addr_tx: got n=%0d %h %h want n=2 e2 20", tx_cnt, tx_log[0],
                     tx_log[1]);
        end
    endtask

    task automatic test_gap_timeout();
        bit to;
        clear_log();
        send_byte(8'h01, 1);
        repeat (GAP_T - 10) @(negedge clk_115200hz);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_wait: got busy=%b want 1", busy);
        end
        repeat (30) @(negedge clk_115200hz);
        n_cmp++;
        if (busy !== 1'b0 || tx_cnt != 0) begin
            n_bad++;
            $display("FAIL gap_drop: got busy=%b tx=%0d want 0 0", busy, tx_cnt);
        end
        send_byte(8'h00, 1);
        send_byte(8'h04, 1);
        wait_idle(200, to);
        n_cmp++;
        if (to || tx_cnt != 2 || tx_log[0] !== 8'h07 || tx_log[1] !== 8'h04) begin
            n_bad++;
            $display("FAIL gap_status: got n=%0d %h %h want n=2 07 04", tx_cnt, tx_log[0],
                     tx_log[1]);
        end
    endtask

    task automatic test_sns_timeout_ovr();
        bit to;
        clear_log();
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        for (int i = 0; i < 50 && !sns_req; i++) @(negedge clk_115200hz);
        send_byte(8'h55, 1);
        wait_idle(1000, to);
        n_cmp++;
        if (to || tx_cnt != 2 || tx_log[0] !== 8'hE4 || tx_log[1] !== 8'h00) begin
            n_bad++;
            $display("FAIL tmo_tx: got n=%0d %h %h want n=2 e4 00", tx_cnt, tx_log[0],
                     tx_log[1]);
        end
        n_cmp++;
        if (req_cycles != SNS_T + 1) begin
            n_bad++;
            $display("FAIL tmo_req_len: got %0d want %0d", req_cycles, SNS_T + 1);
        end
        n_cmp++;
        if (ovr !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_set: got %b want 1", ovr);
        end
        clear_log();
        send_byte(8'h00, 1);
        send_byte(8'h01, 1);
        wait_idle(200, to);
        n_cmp++;
        if (to || tx_cnt != 2 || tx_log[0] !== 8'h07 || tx_log[1] !== 8'h81) begin
            n_bad++;
            $display("FAIL status_ovr: got n=%0d %h %h want n=2 07 81", tx_cnt, tx_log[0],
                     tx_log[1]);
        end
        n_cmp++;
        if (ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_clear: got %b want 0", ovr);
        end
    endtask

    task automatic test_long_level();
        bit to;
        clear_log();
        send_byte(8'h00, 5);
        send_byte(8'h02, 5);
        wait_idle(200, to);
        n_cmp++;
        if (to || tx_cnt != 2 || tx_log[0] !== 8'h07 || tx_log[1] !== 8'h02) begin
            n_bad++;
            $display("FAIL long_level_tx: got n=%0d %h %h want n=2 07 02", tx_cnt, tx_log[0],
                     tx_log[1]);
        end
        n_cmp++;
        if (ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL long_level_ovr: got %b want 0", ovr);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        send_byte(8'h03, 1);
        send_byte(8'h07, 1);
        for (int i = 0; i < 50 && !sns_req; i++) @(negedge clk_115200hz);
        n_cmp++;
        if (sns_req !== 1'b1 || sns_sel !== 5'd7) begin
            n_bad++;
            $display("FAIL mid_pre: got req=%b sel=%0d want 1 7", sns_req, sns_sel);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({sns_req, tx_start, busy, ovr} !== 4'b0000 ||
            {sns_sel, sns_cmd, tx_data} !== 21'h0) begin
            n_bad++;
            $display("FAIL mid_reset: got ctrl=%b data=%h want 0000 0",
                     {sns_req, tx_start, busy, ovr}, {sns_sel, sns_cmd, tx_data});
        end
        repeat (2) @(negedge clk_115200hz);
        rst_n = 1'b1;
        repeat (20) @(negedge clk_115200hz);
        #1;
        n_cmp++;
        if (tx_cnt != 0 || busy !== 1'b0 || sns_req !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_no_resume: got tx=%0d busy=%b req=%b want 0 0 0", tx_cnt, busy,
                     sns_req);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        sns_done = 1'b0;
        sns_err  = 1'b0;
        sns_data = 8'h00;
        test_reset();
        test_sensor_ok();
        test_bad_cmd();
        test_bad_addr();
        test_gap_timeout();
        test_sns_timeout_ovr();
        test_long_level();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_cmd_scheduler.md
Name: uart_cmd_scheduler

Overview:
Command sequencer between the UART receiver, the sensor-channel interfaces and the UART transmitter. It assembles a two-byte request from the Raspberry Pi: a command byte, then an address byte. It validates the request, dispatches it to the addressed sensor channel with a req/done handshake and a timeout, then drives the transmitter to return a two-byte response: code, then payload. Only one request is in flight at a time; this block is the single owner of the sensor bus and the transmitter.

Parameters:
N_SNS, 32, number of sensor channels; valid addresses are 0..N_SNS-1.
ADDR_W, 5, width of sns_sel; N_SNS must be ≤ 2^ADDR_W.
GAP_TIMEOUT, 11520, maximum cycles between the command byte and the address byte (100 ms at 115200 Hz).
SNS_TIMEOUT, 230400, maximum cycles from sns_req to sns_done (2 s).

Ports:
clk_115200hz  in  1  system clock, same clock as the receiver.
rst_n  in  1  asynchronous, active-low reset.
rx_data  in  8  received byte; stable while rx_valid is high.
rx_valid  in  1  receiver "byte ready" level; it may stay high for several cycles.
sns_sel  out  ADDR_W  selected sensor channel.
sns_cmd  out  8  command forwarded to the channel.
sns_req  out  1  request; held high until sns_done.
sns_done  in  1  single-cycle completion strobe from the channel.
sns_err  in  1  channel error; sampled with sns_done.
sns_data  in  8  channel result; sampled with sns_done.
tx_data  out  8  byte to transmit.
tx_start  out  1  single-cycle start pulse to the transmitter.
tx_busy  in  1  transmitter busy; goes high the cycle after tx_start and stays high until the stop bit ends.
busy  out  1  high whenever state is not IDLE.
ovr  out  1  sticky overrun flag.

Behaviour:
- Reset values, asynchronous on rst_n low: state=IDLE; sns_sel=0; sns_cmd=0; sns_req=0; tx_data=0; tx_start=0; busy=0; ovr=0; all counters 0; rx_valid edge register=0.
- Byte event: a rising edge of rx_valid, registered internally. One event per received byte, whatever the length of the level.
- Command set:
  - 0x00 STATUS: answered locally, no sensor access. Response {0x07, {ovr, 2'b00, addr[4:0]}}. Clears ovr after the response is loaded.
  - 0x01 TEMP, 0x02 HUM, 0x03 DIAG: forwarded to the sensor channel.
  - Any other value: invalid command.
- Response codes:
  - 0x08 OK, payload = sns_data.
  - 0xE1 bad command, payload = cmd.
  - 0xE2 bad address, payload = addr.
  - 0xE3 sensor error, payload = sns_data.
  - 0xE4 sensor timeout, payload = 0x00.
- FSM states and transitions:
  - IDLE: on a byte event, latch cmd and go to WAIT_ADDR.
  - WAIT_ADDR: on a byte event, latch addr and go to CHECK. If the gap counter reaches GAP_TIMEOUT, silently discard cmd and return to IDLE; no response is sent.
  - CHECK (1 cycle), priority order:
    - bad command → RESP with 0xE1;
    - addr ≥ N_SNS → RESP with 0xE2;
    - cmd 0x00 → RESP with 0x07;
    - otherwise drive sns_sel and sns_cmd, assert sns_req, go to WAIT_SNS.
  - WAIT_SNS: on sns_done, drop sns_req the same edge and go to RESP with code 0x08 or 0xE3 per sns_err. If the timeout counter reaches SNS_TIMEOUT, drop sns_req and go to RESP with 0xE4. If sns_done and the timeout occur in the same cycle, sns_done wins.
  - RESP: load tx_data=code, pulse tx_start, go to SEND1.
  - SEND1: wait one cycle, then wait for tx_busy low. Then load tx_data=payload, pulse tx_start, go to SEND2.
  - SEND2: same wait, then go to IDLE.
- If tx_busy is already high on entry to RESP, hold until it is low before pulsing tx_start.
- Latency: CHECK to first tx_start is 1 cycle for local responses. sns_done to first tx_start is 1 cycle.
- A byte event in any state other than IDLE or WAIT_ADDR is dropped and sets ovr=1.
- sns_sel and sns_cmd hold their value from CHECK until the next CHECK.
- Counters are 18 bits, cleared on each state entry, and saturate.
- Reset mid-operation aborts immediately: sns_req and tx_start go low, and no partial response is resumed.

Decomposition:
- Shared package uart_pkg: command opcodes, response codes, FSM state encoding, BAUD_CLK_HZ=115200.
- One natural sub-module: rx_edge_detect, which turns the rx_valid level into a single-cycle byte event.
- Both timeouts share a single counter inside the FSM module.

Test Plan:
- Bytes 0x01, 0x03; channel returns done with data 0x19, err=0 after 100 cycles → sns_sel=3, sns_cmd=0x01, sns_req high for 100 cycles; tx bytes 0x08, 0x19; busy falls after the second tx_busy falls.
- Bytes 0x05, 0x00 → no sns_req; tx bytes 0xE1, 0x05.
- Bytes 0x02, 0x20 with N_SNS=32 → tx bytes 0xE2, 0x20.
- Byte 0x01, then nothing for GAP_TIMEOUT cycles → return to IDLE, no tx_start. A following 0x00, 0x04 yields 0x07, 0x04.
- Bytes 0x01, 0x02; no sns_done → sns_req drops at SNS_TIMEOUT; tx bytes 0xE4, 0x00. A third byte sent during WAIT_SNS sets ovr; a later STATUS request for addr 0x01 returns 0x07, 0x81, and ovr=0 afterwards.
- rx_valid held high 5 cycles for one byte → exactly one byte event. rst_n pulled low during WAIT_SNS → all outputs return to reset values within the same cycle.
